// File: rtl/fsm_multiplier_if.sv
// Start/done handshake bundle for the iterative signed multiplier.
// The master drives the operands and start; the slave returns the product, done and busy.
interface fsm_multiplier_if #(
  parameter int M = 8,
  parameter int N = 8
);
  logic                    start;
  logic signed [M-1:0]     A;
  logic signed [N-1:0]     B;
  logic signed [M+N-1:0]   PRODUCT;
  logic                    done;
  logic                    busy;

  modport master (output start, A, B, input PRODUCT, done, busy);
  modport slave  (input start, A, B, output PRODUCT, done, busy);
endinterface

// File: rtl/fsm_multiplier.sv
// Iterative signed shift-and-add multiplier: one adder and one shifter, one multiplier bit per cycle.
// Define FSM_MULT_EARLY_EXIT_EN to leave MULT as soon as the remaining multiplier bits are all zero.
module fsm_multiplier #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fsm_multiplier_if.slave   bus
);

  localparam int W  = M + N;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, MULT, FINISH} state_t;

  state_t         state;
  logic [M-1:0]   a_mag;
  logic [N-1:0]   b_reg;
  logic           neg;
  logic [W-1:0]   acc;
  logic [CW-1:0]  shift;
  logic [CW-1:0]  count;

  logic [M-1:0]   a_abs;
  logic [N-1:0]   b_abs;
  logic [W-1:0]   addend;
  logic [N-1:0]   b_next;
  logic [CW-1:0]  count_next;
  logic           last_iter;

  // Negating the most-negative value wraps to itself, which read as unsigned is the correct magnitude.
  assign a_abs      = bus.A[M-1] ? $unsigned(-bus.A) : $unsigned(bus.A);
  assign b_abs      = bus.B[N-1] ? $unsigned(-bus.B) : $unsigned(bus.B);
  assign addend     = W'(a_mag) << shift;
  assign b_next     = b_reg >> 1;
  assign count_next = count - CW'(1);

`ifdef FSM_MULT_EARLY_EXIT_EN
  assign last_iter  = (count_next == '0) || (b_next == '0);
`else
  assign last_iter  = (count_next == '0);
`endif

  // NOTE: every register is assigned with <= so all state updates on the same edge see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are cleared too, so an abandoned operation leaves nothing behind.
      state       <= IDLE;
      a_mag       <= '0;
      b_reg       <= '0;
      neg         <= 1'b0;
      acc         <= '0;
      shift       <= '0;
      count       <= '0;
      bus.PRODUCT <= '0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          if (bus.start) begin
            a_mag    <= a_abs;
            b_reg    <= b_abs;
            neg      <= bus.A[M-1] ^ bus.B[N-1];
            acc      <= '0;
            shift    <= '0;
            count    <= CW'(N);
            bus.busy <= 1'b1;
            state    <= MULT;
          end
        end

        MULT: begin
          if (b_reg[0]) acc <= acc + addend;
          b_reg <= b_next;
          shift <= shift + CW'(1);
          count <= count_next;
          if (last_iter) state <= FINISH;
        end

        FINISH: begin
          bus.PRODUCT <= neg ? $signed(-acc) : $signed(acc);
          bus.done    <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_multiplier.sv
// Scoreboard bench for fsm_multiplier: stimulus pushes expected product and done cycle,
// a monitor pops and compares on every done pulse.
module tb_fsm_multiplier;

  localparam int M = 8;
  localparam int N = 8;

  typedef struct {
    logic signed [M+N-1:0] prod;
    int                    cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycle;
  int   checks;
  int   errors;
  exp_t sb[$];

  fsm_multiplier_if #(.M(M), .N(N)) bus ();

  fsm_multiplier #(.M(M), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Edges from start capture to the edge after which done is visible.
  function automatic int lat(input int b);
    int mag;
    int hb;
    mag = (b < 0) ? -b : b;
    hb  = 0;
    for (int i = 0; i < N + 1; i++)
      if (((mag >> i) & 1) == 1) hb = i;
`ifdef FSM_MULT_EARLY_EXIT_EN
    return (hb + 2 < 2) ? 2 : hb + 2;
`else
    return N + 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", bus.PRODUCT, e.prod);
        check("done_cycle", cycle, e.cyc);
        check("busy_at_done", bus.busy, 0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("done_timeout_pending", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic run_op(input int a, input int b, input int exp);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = M'(a);
    bus.B     = N'(b);
    @(negedge clk);
    bus.start = 1'b0;
    k = cycle;
    sb.push_back('{prod: (M+N)'(exp), cyc: k + lat(b)});
    check("busy_after_start", bus.busy, 1);
    wait_idle();
  endtask

  initial begin
    int k;
    int cap;
    checks    = 0;
    errors    = 0;
    cycle     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    @(negedge clk);
    check("reset_product", bus.PRODUCT, 0);
    check("reset_done", bus.done, 0);
    check("reset_busy", bus.busy, 0);
    rst_n = 1'b1;

    run_op(7, -3, -21);
    run_op(-128, -128, 16384);
    run_op(-128, 127, -16256);
    run_op(0, -55, 0);
    run_op(100, 0, 0);
    run_op(127, 127, 16129);
    run_op(-1, -1, 1);
    run_op(-9, 1, -9);
    run_op(2, 64, 128);

    repeat (5) @(negedge clk);
    check("product_hold", bus.PRODUCT, 128);

    // Start ignored while busy, then held high for a back-to-back capture.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'sd5;
    bus.B     = 8'sd6;
    @(negedge clk);
    bus.start = 1'b0;
    k   = cycle;
    cap = k + lat(6) + 1;
    sb.push_back('{prod: 16'sd30, cyc: k + lat(6)});
    sb.push_back('{prod: 16'sd81, cyc: cap + lat(9)});
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'sd9;
    bus.B     = 8'sd9;
    while (cycle < cap) begin
      if (cycle == cap - 1) check("busy_before_recapture", bus.busy, 0);
      @(negedge clk);
    end
    check("busy_after_recapture", bus.busy, 1);
    bus.start = 1'b0;
    wait_idle();

    // Reset mid-operation abandons it with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'sd12;
    bus.B     = 8'sd12;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midop_reset_product", bus.PRODUCT, 0);
    check("midop_reset_done", bus.done, 0);
    check("midop_reset_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", bus.PRODUCT, 0);
    run_op(3, 4, 12);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
